decode38_seq: RTL and testbench

DECODE38_SEQ -- requirements
Module: decode38_seq

---
 rtl/decode38_seq.sv | 142 ++++++++++++++
 tb/tb_decode38_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/decode38_seq.sv
// rtl/decode38_seq.sv - queued 3-to-8 decoder that shows each one-hot pattern for HOLD cycles, separated by GAP zero cycles
module decode38_seq #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       code_valid,
  input  logic [2:0] code,
  output logic       code_ready,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       busy,
  output logic [7:0] shown_cnt
);

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] GAP_M1  = 8'(GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;

  state_t     state, state_d;
  logic [2:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic [7:0] cnt, cnt_d;
  logic [7:0] y_d;
  logic       y_valid_d;
  logic       push, pop, fifo_ne;

  assign code_ready = (count < 3'd4);
  assign fifo_ne    = (count != 3'd0);
  assign push       = code_valid && code_ready;
  assign busy       = (state != ST_IDLE) || fifo_ne;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= code;
    end
  end

  // Pointers and occupancy are reset, so a handshake during reset never lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ena && fifo_ne) begin
          pop     = 1'b1;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt == 8'd0) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt == 8'd0) begin
          if (ena && fifo_ne) begin
            pop     = 1'b1;
            state_d = ST_SHOW;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    y_d       = y;
    y_valid_d = y_valid;
    cnt_d     = cnt;
    if (pop) begin
      y_d       = 8'd1 << mem[rd_ptr];
      y_valid_d = 1'b1;
      cnt_d     = HOLD_M1;
    end else begin
      case (state)
        ST_SHOW: begin
          if (cnt != 8'd0) begin
            cnt_d = cnt - 8'd1;
          end else begin
            y_d       = 8'h00;
            y_valid_d = 1'b0;
            cnt_d     = GAP_M1;
          end
        end
        ST_GAP: begin
          y_d       = 8'h00;
          y_valid_d = 1'b0;
          if (cnt != 8'd0) cnt_d = cnt - 8'd1;
        end
        default: begin
          y_d       = 8'h00;
          y_valid_d = 1'b0;
          cnt_d     = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y         <= 8'h00;
      y_valid   <= 1'b0;
      cnt       <= 8'd0;
      shown_cnt <= 8'd0;
    end else begin
      y         <= y_d;
      y_valid   <= y_valid_d;
      cnt       <= cnt_d;
      if (pop) shown_cnt <= shown_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_decode38_seq.sv
// tb/tb_decode38_seq.sv - scoreboard bench for decode38_seq with randomized and directed stimulus
module tb_decode38_seq;

  localparam int HOLD = 4;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       code_valid = 1'b0;
  logic [2:0] code = 3'd0;
  logic       code_ready;
  logic [7:0] y;
  logic       y_valid;
  logic       busy;
  logic [7:0] shown_cnt;

  int total = 0;
  int bad = 0;

  logic [2:0] sb_q[$];

  decode38_seq #(.HOLD(HOLD), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .code_valid(code_valid), .code(code),
    .code_ready(code_ready), .y(y), .y_valid(y_valid), .busy(busy), .shown_cnt(shown_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: at each falling edge the outputs reflect the rising edge just passed,
  // and ena/rst_n still hold the values that edge sampled.
  int         zcnt = 1000;
  int         run = 0;
  int         q_prev = 0;
  logic       yv_prev = 1'b0;
  logic [2:0] cur = 3'd0;
  int         exp_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_cnt = 0;
      zcnt    = 1000;
      run     = 0;
      chk("rst_y", int'(y), 0);
      chk("rst_y_valid", int'(y_valid), 0);
      chk("rst_shown_cnt", int'(shown_cnt), 0);
      chk("rst_code_ready", int'(code_ready), 1);
      chk("rst_busy", int'(busy), 0);
      q_prev  = 0;
      yv_prev = 1'b0;
    end else begin
      logic start_exp, rise;
      start_exp = !yv_prev && (zcnt >= GAP) && ena && (q_prev > 0);
      rise      = y_valid && !yv_prev;
      chk("pattern_start", int'(rise), int'(start_exp));
      if (rise) begin
        if (sb_q.size() == 0) chk("start_with_empty_model", 1, 0);
        else cur = sb_q.pop_front();
        exp_cnt = (exp_cnt + 1) % 256;
        run = 0;
      end
      if (y_valid) begin
        run++;
        chk("y_onehot", int'(y), 1 << cur);
        if (run > HOLD) chk("hold_too_long", run, HOLD);
        zcnt = 0;
      end else begin
        chk("y_zero", int'(y), 0);
        if (yv_prev) chk("hold_len", run, HOLD);
        if (zcnt < 1000) zcnt++;
      end
      chk("shown_cnt", int'(shown_cnt), exp_cnt);
      chk("code_ready", int'(code_ready), int'(sb_q.size() < 4));
      chk("busy", int'(busy), int'(y_valid || (zcnt >= 1 && zcnt <= GAP) || sb_q.size() > 0));
      q_prev  = sb_q.size();
      yv_prev = y_valid;
    end
  end

  task automatic step(input logic r, input logic e, input logic v, input logic [2:0] c);
    @(negedge clk);
    #1;
    rst_n      = r;
    ena        = e;
    code_valid = v;
    code       = c;
    if (r && v && code_ready) sb_q.push_back(c);
  endtask

  initial begin
    int t;
    step(1'b0, 1'b1, 1'b1, 3'd3);
    step(1'b0, 1'b1, 1'b0, 3'd0);

    // single code
    step(1'b1, 1'b1, 1'b1, 3'd5);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 3'd0);

    // back-to-back
    step(1'b1, 1'b1, 1'b1, 3'd0);
    step(1'b1, 1'b1, 1'b1, 3'd7);
    step(1'b1, 1'b1, 1'b1, 3'd3);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 3'd0);

    // full FIFO with ena low, then drain
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 1'b1, 3'(i));
    step(1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0, 3'd0);

    // ena dropped during SHOW with a code queued
    step(1'b1, 1'b1, 1'b1, 3'd2);
    step(1'b1, 1'b1, 1'b1, 3'd6);
    step(1'b1, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 3'd0);

    // reset during SHOW with codes pending
    step(1'b1, 1'b1, 1'b1, 3'd1);
    step(1'b1, 1'b1, 1'b1, 3'd4);
    step(1'b1, 1'b1, 1'b1, 3'd6);
    step(1'b1, 1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 3'd0);

    // long saturating run to wrap shown_cnt
    for (int i = 0; i < 1400; i++) step(1'b1, 1'b1, 1'b1, 3'($urandom_range(0, 7)));

    // random traffic with occasional reset
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) != 0),
           $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));

    // bounded drain
    t = 0;
    while ((busy || sb_q.size() != 0) && t < 200) begin
      step(1'b1, 1'b1, 1'b0, 3'd0);
      t++;
    end
    chk("drain_timeout", int'(busy || sb_q.size() != 0), 0);
    step(1'b1, 1'b1, 1'b0, 3'd0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
